timer_irq: RTL and testbench
============================

Name: timer_irq

Overview:
- Memory-mapped 32-bit machine timer on the peripheral bus.
- Raises the timer interrupt vector consumed by the core's interrupt arbiter as its int_flag input.
- Counts enabled clock ticks and compares against a programmable reload value. Supports periodic or one-shot mode, a sticky pending flag cleared by write-1-to-clear, and an interrupt enable gate.

Parameters:
- TIMER_INT_BIT, 0, bit index of int_sig_o driven by this timer; all other bits tie to 0.

Ports:
- clk_i  input  1  system clock
- rst_ni  input  1  reset; asynchronous, active-low
- req_i  input  1  bus access strobe, single-cycle
- we_i  input  1  write when 1, read when 0 (qualified by req_i)
- addr_i  input  32  byte address; only addr_i[3:2] decoded
- data_i  input  32  write data
- data_o  output  32  read data, combinational, valid in the req_i cycle
- int_sig_o  output  INT_BUS  interrupt vector to core; bit TIMER_INT_BIT = PEND & IE

Behaviour:
- Register map, by addr_i[3:2]:
  - 0 CTRL: [0] EN, [1] IE, [2] PEND (read; write-1-to-clear), [3] ONESHOT, [31:4] read 0.
  - 1 COUNT: r/w.
  - 2 VALUE: r/w.
  - 3 PRESC: see Optional Feature.
- Reset (async, rst_ni low): CTRL=0, COUNT=0, VALUE=0, PRESC=0, int_sig_o=0.
- data_o:
  - While req_i=1 & we_i=0: data_o is the selected register.
  - Otherwise data_o=0.
  - Reading has no side effects.
- Writes take effect at the posedge of the req_i & we_i cycle. Writing CTRL updates EN, IE and ONESHOT directly. Writing 1 to PEND clears it; writing 0 leaves it unchanged.
- tick: 1 every cycle while EN=1 (prescaled when the feature is on).
- Count step, when tick=1 and no COUNT write this cycle:
  - If VALUE!=0 and COUNT==VALUE-1: COUNT<=0 and PEND<=1. If ONESHOT=1, also EN<=0.
  - Otherwise COUNT<=COUNT+1, wrapping from 0xFFFFFFFF to 0.
- VALUE==0: the timer free-runs with no match and never sets PEND.
- Period: an interrupt occurs every VALUE ticks. Latency: PEND and int_sig_o rise one cycle after the tick on which COUNT==VALUE-1 (registered).
- Simultaneous events:
  - COUNT write plus tick: the written value wins and no match is evaluated that cycle.
  - PEND W1C plus match set in the same cycle: set wins, so the interrupt is not lost.
  - CTRL write plus ONESHOT auto-clear of EN in the same cycle: the bus write value of EN wins.
  - VALUE write: the new value is used from the next cycle. If a VALUE write makes VALUE <= COUNT, the counter runs to the wrap before matching.
- EN=0 freezes COUNT. IE=0 masks int_sig_o but PEND still sets.
- int_sig_o is registered as (PEND & IE) at bit TIMER_INT_BIT. It stays high until software clears PEND or IE.
- Reset mid-count: all state returns to reset values immediately; int_sig_o drops asynchronously.

Optional Feature:
- Macro: TIMER_PRESCALER_EN.
- When defined:
  - PRESC[7:0] is r/w (upper bits read 0), with an 8-bit internal divider cnt_div.
  - tick=1 when EN=1 & cnt_div==PRESC. cnt_div then resets to 0; otherwise it increments while EN=1.
  - cnt_div clears on EN=0 and on any PRESC write. PRESC=0 gives a tick every cycle.
- When undefined:
  - tick=EN.
  - PRESC reads 0 and writes are ignored.
  - No divider logic exists.

Test Plan:
- Reset → CTRL/COUNT/VALUE read 0; int_sig_o=0; EN=0, so COUNT stays 0 for 20 cycles.
- VALUE=5, CTRL=0x3 (EN|IE) → COUNT sequence 1,2,3,4,0. PEND=1 and int_sig_o[TIMER_INT_BIT]=1 the cycle after COUNT was 4. Periodic rematch every 5 cycles.
- Write CTRL bit2=1 in the cycle a match fires → PEND stays 1. W1C on a later non-match cycle → PEND=0 and int_sig_o=0 next cycle.
- ONESHOT: VALUE=3, CTRL=0xB → single PEND, then EN reads 0 and COUNT stays 0.
- VALUE=0, COUNT=0xFFFFFFFE, EN=1 → COUNT reads 0xFFFFFFFF, then 0. PEND never sets.
- TIMER_PRESCALER_EN defined, PRESC=2, VALUE=2, EN|IE → COUNT increments every 3 cycles. PEND sets 6 cycles after enable (+1 registered). Assert rst_ni low mid-count → all registers 0 and int_sig_o=0 immediately.

Source files
------------

// File: rtl/timer_irq.sv
// timer_irq: memory-mapped 32-bit machine timer with periodic/one-shot match and sticky W1C pending flag.
// Define TIMER_PRESCALER_EN to add the 8-bit PRESC register and tick divider.
module timer_irq #(
  parameter int TIMER_INT_BIT = 0,
  parameter int INT_BUS       = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req_i,
  input  logic               we_i,
  input  logic [31:0]        addr_i,
  input  logic [31:0]        data_i,
  output logic [31:0]        data_o,
  output logic [INT_BUS-1:0] int_sig_o
);
  logic        en_q, en_d, ie_q, ie_d, pend_q, pend_d, one_q, one_d, int_q, int_d;
  logic [31:0] count_q, count_d, value_q, value_d, presc_rd;
  logic        wr, wr_ctrl, wr_count, wr_value, tick, match;
  logic [1:0]  sel;
  logic        unused_addr;
  assign unused_addr = ^{addr_i[31:4], addr_i[1:0]};
  assign sel      = addr_i[3:2];
  assign wr       = req_i & we_i;
  assign wr_ctrl  = wr & (sel == 2'd0);
  assign wr_count = wr & (sel == 2'd1);
  assign wr_value = wr & (sel == 2'd2);
`ifdef TIMER_PRESCALER_EN
  logic [7:0] presc_q, presc_d, div_q, div_d;
  logic       wr_presc;
  assign wr_presc = wr & (sel == 2'd3);
  assign tick     = en_q & (div_q == presc_q);
  assign presc_d  = wr_presc ? data_i[7:0] : presc_q;
  assign div_d    = (!en_q || wr_presc || tick) ? 8'd0 : div_q + 8'd1;
  assign presc_rd = {24'd0, presc_q};
`else
  assign tick     = en_q;
  assign presc_rd = '0;
`endif
  // A COUNT write in the same cycle suppresses matching entirely.
  assign match   = tick & ~wr_count & (value_q != 32'd0) & (count_q == value_q - 32'd1);
  assign count_d = wr_count ? data_i : !tick ? count_q : match ? 32'd0 : count_q + 32'd1;
  assign value_d = wr_value ? data_i : value_q;
  assign en_d    = wr_ctrl ? data_i[0] : en_q & ~(match & one_q);
  assign ie_d    = wr_ctrl ? data_i[1] : ie_q;
  assign one_d   = wr_ctrl ? data_i[3] : one_q;
  assign pend_d  = match | (pend_q & ~(wr_ctrl & data_i[2]));
  assign int_d   = pend_d & ie_d;
  assign data_o  = !(req_i && !we_i) ? 32'd0 :
                   sel == 2'd0 ? {28'd0, one_q, pend_q, ie_q, en_q} :
                   sel == 2'd1 ? count_q :
                   sel == 2'd2 ? value_q : presc_rd;
  always_comb begin
    int_sig_o = '0;
    int_sig_o[TIMER_INT_BIT] = int_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_q    <= 1'b0;
      ie_q    <= 1'b0;
      pend_q  <= 1'b0;
      one_q   <= 1'b0;
      int_q   <= 1'b0;
      count_q <= '0;
      value_q <= '0;
`ifdef TIMER_PRESCALER_EN
      presc_q <= '0;
      div_q   <= '0;
`endif
    end else begin
      en_q    <= en_d;
      ie_q    <= ie_d;
      pend_q  <= pend_d;
      one_q   <= one_d;
      int_q   <= int_d;
      count_q <= count_d;
      value_q <= value_d;
`ifdef TIMER_PRESCALER_EN
      presc_q <= presc_d;
      div_q   <= div_d;
`endif
    end
  end
endmodule

// File: tb/tb_timer_irq.sv
// tb_timer_irq: directed self-checking bench for timer_irq; inputs change and outputs are sampled on negedges.
module tb_timer_irq;
  logic        clk = 0, rst_n = 0, req = 0, we = 0;
  logic [31:0] addr = 0, wdata = 0, rdata, ints;
  int          total = 0, bad = 0;
  timer_irq #(.TIMER_INT_BIT(0), .INT_BUS(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_i(addr),
    .data_i(wdata), .data_o(rdata), .int_sig_o(ints)
  );
  always #5 clk = ~clk;
  // Called at a negedge; the write lands on the very next posedge.
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    req = 1; we = 1; addr = {28'd0, a}; wdata = d;
    @(negedge clk);
    req = 0; we = 0; wdata = 0;
  endtask
  // Combinational read that consumes no clock cycle.
  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    req = 1; we = 0; addr = {28'd0, a};
    #1 d = rdata;
    req = 0;
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic test_reset;
    logic [31:0] v;
    repeat (3) @(negedge clk);
    rst_n = 1;
    for (int a = 0; a < 16; a += 4) begin
      rd(a[3:0], v); total++;
      if (v !== 32'd0) begin bad++; $display("FAIL reset_reg%0d got=%h exp=0", a, v); end
    end
    total++;
    if (ints !== 32'd0) begin bad++; $display("FAIL reset_int got=%h exp=0", ints); end
    step(20);
    rd(4, v); total++;
    if (v !== 32'd0) begin bad++; $display("FAIL reset_frozen got=%h exp=0", v); end
    rd(1, v); total++;
    if (rdata !== 32'd0) begin bad++; $display("FAIL idle_data_o got=%h exp=0", rdata); end
  endtask
  task automatic test_periodic;
    logic [31:0] v, exp_c [5];
    exp_c = '{1, 2, 3, 4, 0};
    wr(8, 5);
    wr(0, 3);
    for (int i = 0; i < 5; i++) begin
      step(1);
      rd(4, v); total++;
      if (v !== exp_c[i]) begin bad++; $display("FAIL periodic_count%0d got=%h exp=%h", i, v, exp_c[i]); end
      rd(0, v); total++;
      if (v[2] !== (i == 4)) begin bad++; $display("FAIL periodic_pend%0d got=%b exp=%b", i, v[2], i == 4); end
    end
    total++;
    if (ints !== 32'd1) begin bad++; $display("FAIL periodic_int got=%h exp=1", ints); end
  endtask
  task automatic test_w1c;
    logic [31:0] v;
    wr(0, 7);
    rd(0, v); total++;
    if (v !== 32'h3) begin bad++; $display("FAIL w1c_clear got=%h exp=3", v); end
    total++;
    if (ints !== 32'd0) begin bad++; $display("FAIL w1c_int got=%h exp=0", ints); end
    step(3);
    rd(4, v); total++;
    if (v !== 32'd4) begin bad++; $display("FAIL w1c_pre_count got=%h exp=4", v); end
    wr(0, 7);
    rd(0, v); total++;
    if (v !== 32'h7) begin bad++; $display("FAIL w1c_vs_set got=%h exp=7", v); end
    rd(4, v); total++;
    if (v !== 32'd0) begin bad++; $display("FAIL rematch_count got=%h exp=0", v); end
    wr(0, 4);
    step(3);
    rd(4, v); total++;
    if (v !== 32'd1) begin bad++; $display("FAIL disable_freeze got=%h exp=1", v); end
  endtask
  task automatic test_mask;
    logic [31:0] v;
    wr(8, 2);
    wr(4, 0);
    wr(0, 1);
    step(2);
    rd(0, v); total++;
    if (v !== 32'h5) begin bad++; $display("FAIL mask_pend got=%h exp=5", v); end
    total++;
    if (ints !== 32'd0) begin bad++; $display("FAIL mask_int got=%h exp=0", ints); end
    wr(0, 3);
    total++;
    if (ints !== 32'd1) begin bad++; $display("FAIL unmask_int got=%h exp=1", ints); end
    wr(0, 0);
    wr(0, 4);
    rd(0, v); total++;
    if (v !== 32'd0) begin bad++; $display("FAIL mask_cleanup got=%h exp=0", v); end
  endtask
  task automatic test_oneshot;
    logic [31:0] v;
    wr(4, 0);
    wr(8, 3);
    wr(0, 32'hB);
    step(3);
    rd(0, v); total++;
    if (v !== 32'hE) begin bad++; $display("FAIL oneshot_ctrl got=%h exp=e", v); end
    step(5);
    rd(4, v); total++;
    if (v !== 32'd0) begin bad++; $display("FAIL oneshot_count got=%h exp=0", v); end
    rd(0, v); total++;
    if (v !== 32'hE) begin bad++; $display("FAIL oneshot_stays got=%h exp=e", v); end
    wr(0, 4);
  endtask
  task automatic test_wrap;
    logic [31:0] v, exp_c [3];
    exp_c = '{32'hFFFFFFFF, 32'd0, 32'd1};
    wr(8, 0);
    wr(4, 32'hFFFFFFFE);
    wr(0, 1);
    rd(4, v); total++;
    if (v !== 32'hFFFFFFFE) begin bad++; $display("FAIL wrap_start got=%h exp=fffffffe", v); end
    for (int i = 0; i < 3; i++) begin
      step(1);
      rd(4, v); total++;
      if (v !== exp_c[i]) begin bad++; $display("FAIL wrap_count%0d got=%h exp=%h", i, v, exp_c[i]); end
      rd(0, v); total++;
      if (v[2] !== 1'b0) begin bad++; $display("FAIL wrap_pend%0d got=%b exp=0", i, v[2]); end
    end
    wr(4, 100);
    rd(4, v); total++;
    if (v !== 32'd100) begin bad++; $display("FAIL count_write_wins got=%h exp=64", v); end
    wr(0, 0);
  endtask
  task automatic test_presc;
    logic [31:0] v;
    wr(4, 0);
    wr(8, 2);
    wr(12, 2);
`ifdef TIMER_PRESCALER_EN
    rd(12, v); total++;
    if (v !== 32'd2) begin bad++; $display("FAIL presc_read got=%h exp=2", v); end
    wr(0, 3);
    step(2);
    rd(4, v); total++;
    if (v !== 32'd0) begin bad++; $display("FAIL presc_hold got=%h exp=0", v); end
    step(1);
    rd(4, v); total++;
    if (v !== 32'd1) begin bad++; $display("FAIL presc_tick got=%h exp=1", v); end
    step(2);
    rd(0, v); total++;
    if (v[2] !== 1'b0) begin bad++; $display("FAIL presc_early_pend got=%b exp=0", v[2]); end
    step(1);
    rd(0, v); total++;
    if (v[2] !== 1'b1) begin bad++; $display("FAIL presc_pend got=%b exp=1", v[2]); end
`else
    rd(12, v); total++;
    if (v !== 32'd0) begin bad++; $display("FAIL presc_absent got=%h exp=0", v); end
    wr(0, 3);
    step(2);
    rd(0, v); total++;
    if (v[2] !== 1'b1) begin bad++; $display("FAIL nopresc_pend got=%b exp=1", v[2]); end
`endif
  endtask
  task automatic test_reset_mid;
    logic [31:0] v;
    total++;
    if (ints !== 32'd1) begin bad++; $display("FAIL premid_int got=%h exp=1", ints); end
    #2 rst_n = 0;
    #1;
    total++;
    if (ints !== 32'd0) begin bad++; $display("FAIL midreset_int got=%h exp=0", ints); end
    for (int a = 0; a < 16; a += 4) begin
      rd(a[3:0], v); total++;
      if (v !== 32'd0) begin bad++; $display("FAIL midreset_reg%0d got=%h exp=0", a, v); end
    end
    @(negedge clk);
    rst_n = 1;
  endtask
  initial begin
    test_reset;
    test_periodic;
    test_w1c;
    test_mask;
    test_oneshot;
    test_wrap;
    test_presc;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
